// File: rtl/pmem_arbiter.sv
// Two-requester line arbiter: icache and dcache share one physical-memory port.
// One owner at a time; the command is latched on grant and replayed until pmem_resp.
module pmem_arbiter #(
  parameter bit          DCACHE_PRIORITY = 1'b1,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_read,
  input  logic [15:0]  i_address,
  output logic [127:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [15:0]  d_address,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  localparam bit         STARVE_EN = (STARVE_LIMIT != 0);
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  state_t         state;
  logic           cmd_read;
  logic           cmd_write;
  logic [15:0]    cmd_addr;
  logic [127:0]   cmd_wdata;
  logic [3:0]     starve_cnt;
  logic           last_grant;   // 1 = dcache was granted last
  logic           d_req;
  logic           force_i;
  logic           grant_d;
  logic           grant_i;
  logic           serving;

  always_comb begin
    d_req   = d_read | d_write;
    force_i = STARVE_EN && (starve_cnt == LIMIT);
    // dcache wins a tie unless icache is starved; round-robin favours the side not served last
    grant_d = d_req && (!i_read || (!force_i && (DCACHE_PRIORITY || !last_grant)));
    grant_i = i_read && !grant_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cmd_read   <= 1'b0;
      cmd_write  <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      starve_cnt <= '0;
      last_grant <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= SERVE_D;
            cmd_write  <= d_write;
            cmd_read   <= ~d_write;  // read+write together is a writeback
            cmd_addr   <= d_address;
            cmd_wdata  <= d_wdata;
            last_grant <= 1'b1;
            if (!i_read)                 starve_cnt <= '0;
            else if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
          end else if (grant_i) begin
            state      <= SERVE_I;
            cmd_read   <= 1'b1;
            cmd_write  <= 1'b0;
            cmd_addr   <= i_address;
            cmd_wdata  <= '0;
            last_grant <= 1'b0;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        SERVE_I, SERVE_D: if (pmem_resp) state <= RELEASE;
        default:          state <= IDLE;
      endcase
    end
  end

  always_comb begin
    serving      = (state == SERVE_I) || (state == SERVE_D);
    pmem_read    = serving & cmd_read;
    pmem_write   = serving & cmd_write;
    pmem_address = serving ? cmd_addr  : '0;
    pmem_wdata   = serving ? cmd_wdata : '0;
    i_resp       = (state == SERVE_I) & pmem_resp;
    d_resp       = (state == SERVE_D) & pmem_resp;
    i_rdata      = i_resp ? pmem_rdata : '0;
    d_rdata      = d_resp ? pmem_rdata : '0;
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a priority/starvation instance and a round-robin
// instance share the same stimulus; immediate assertions check each step.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_read, d_read, d_write, pmem_resp;
  logic [15:0]  i_address, d_address;
  logic [127:0] d_wdata, pmem_rdata;

  logic [127:0] p_i_rdata, p_d_rdata, p_pmem_wdata, r_i_rdata, r_d_rdata, r_pmem_wdata;
  logic         p_i_resp, p_d_resp, p_pmem_read, p_pmem_write;
  logic         r_i_resp, r_d_resp, r_pmem_read, r_pmem_write;
  logic [15:0]  p_pmem_address, r_pmem_address;

  int checks   = 0;
  int failures = 0;

  localparam logic [15:0]  IA   = 16'h0111;
  localparam logic [15:0]  DA   = 16'h0222;
  localparam logic [127:0] PA5  = {16{8'hA5}};
  localparam logic [127:0] WPAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  always #5 clk = ~clk;

  pmem_arbiter #(.DCACHE_PRIORITY(1'b1), .STARVE_LIMIT(2)) u_prio (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(p_i_rdata), .i_resp(p_i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(p_d_rdata), .d_resp(p_d_resp),
    .pmem_read(p_pmem_read), .pmem_write(p_pmem_write), .pmem_address(p_pmem_address),
    .pmem_wdata(p_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  pmem_arbiter #(.DCACHE_PRIORITY(1'b0), .STARVE_LIMIT(0)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(r_i_rdata), .i_resp(r_i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(r_d_rdata), .d_resp(r_d_resp),
    .pmem_read(r_pmem_read), .pmem_write(r_pmem_write), .pmem_address(r_pmem_address),
    .pmem_wdata(r_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  // Wait (bounded) for a transaction on u_prio, capture both instances' addresses, complete it.
  task automatic serve(output logic [15:0] pa, output logic [15:0] ra);
    bit found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      if (p_pmem_read || p_pmem_write) found = 1;
    end
    chk("grant_seen", 128'(found), 128'd1);
    pa = p_pmem_address;
    ra = r_pmem_address;
    pmem_rdata = PA5;
    pmem_resp  = 1;
    #1;
    chk("serve_resp", 128'(p_i_resp | p_d_resp), 128'd1);
    tick();
    pmem_resp = 0;
  endtask

  logic [15:0] exp_p [6];
  logic [15:0] exp_r [6];
  logic [15:0] pa, ra;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_p = '{DA, DA, IA, DA, DA, IA};
    exp_r = '{DA, IA, DA, IA, DA, IA};

    // reset state
    do_reset();
    #1;
    chk("rst_pmem_read",  128'(p_pmem_read),  0);
    chk("rst_pmem_write", 128'(p_pmem_write), 0);
    chk("rst_pmem_addr",  128'(p_pmem_address), 0);
    chk("rst_i_resp",     128'(p_i_resp), 0);
    chk("rst_d_resp",     128'(p_d_resp), 0);

    // icache-only read, one-cycle turnaround, held until pmem_resp
    i_read = 1; i_address = 16'h0120;
    tick();
    chk("t1_pmem_read",  128'(p_pmem_read), 1);
    chk("t1_pmem_write", 128'(p_pmem_write), 0);
    chk("t1_pmem_addr",  128'(p_pmem_address), 128'h0120);
    chk("t1_pmem_wdata", p_pmem_wdata, 0);
    chk("t1_i_resp_wait", 128'(p_i_resp), 0);
    tick();
    chk("t1_hold_read", 128'(p_pmem_read), 1);
    pmem_rdata = PA5; pmem_resp = 1;
    #1;
    chk("t1_i_resp",  128'(p_i_resp), 1);
    chk("t1_i_rdata", p_i_rdata, PA5);
    chk("t1_d_resp",  128'(p_d_resp), 0);
    chk("t1_d_rdata", p_d_rdata, 0);
    tick();
    pmem_resp = 0; i_read = 0;
    #1;
    chk("t1_release_read", 128'(p_pmem_read), 0);
    chk("t1_release_resp", 128'(p_i_resp), 0);
    tick();

    // simultaneous request, dcache priority; read+write treated as write
    i_read = 1; i_address = IA;
    d_read = 1; d_write = 1; d_address = 16'h0333; d_wdata = WPAT;
    tick();
    chk("t2_pmem_write", 128'(p_pmem_write), 1);
    chk("t2_pmem_read",  128'(p_pmem_read), 0);
    chk("t2_pmem_addr",  128'(p_pmem_address), 128'h0333);
    chk("t2_pmem_wdata", p_pmem_wdata, WPAT);
    pmem_rdata = PA5; pmem_resp = 1;
    #1;
    chk("t2_d_resp", 128'(p_d_resp), 1);
    chk("t2_i_resp", 128'(p_i_resp), 0);
    tick();
    pmem_resp = 0; d_read = 0; d_write = 0;
    #1;
    chk("t2_release_write", 128'(p_pmem_write), 0);
    tick();
    chk("t2_idle_read", 128'(p_pmem_read), 0);
    tick();
    chk("t2_i_read",  128'(p_pmem_read), 1);
    chk("t2_i_addr",  128'(p_pmem_address), 128'(IA));
    chk("t2_i_wdata", p_pmem_wdata, 0);
    pmem_resp = 1;
    #1;
    chk("t2_i_resp", 128'(p_i_resp), 1);
    tick();
    pmem_resp = 0; i_read = 0;
    tick();

    // latched command survives a changing / dropped request
    d_read = 1; d_address = 16'h0040;
    tick();
    d_address = 16'h0FF0; d_read = 0;
    #1;
    chk("t5_addr_a", 128'(p_pmem_address), 128'h0040);
    chk("t5_read",   128'(p_pmem_read), 1);
    tick();
    chk("t5_addr_b", 128'(p_pmem_address), 128'h0040);
    pmem_resp = 1;
    #1;
    chk("t5_d_resp", 128'(p_d_resp), 1);
    chk("t5_addr_c", 128'(p_pmem_address), 128'h0040);
    tick();
    pmem_resp = 0;
    tick();

    // starvation limit (u_prio) and round-robin (u_rr), both requesting continuously
    do_reset();
    i_read = 1; i_address = IA; d_read = 1; d_address = DA;
    for (int g = 0; g < 6; g++) begin
      serve(pa, ra);
      chk($sformatf("t3_prio_grant%0d", g), 128'(pa), 128'(exp_p[g]));
      chk($sformatf("t4_rr_grant%0d", g),   128'(ra), 128'(exp_r[g]));
    end
    i_read = 0; d_read = 0;

    // reset mid-transaction abandons it
    do_reset();
    i_read = 1; i_address = 16'h0120;
    tick();
    chk("t6_serving", 128'(p_pmem_read), 1);
    reset_n = 0;
    tick();
    chk("t6_pmem_read",  128'(p_pmem_read), 0);
    chk("t6_pmem_addr",  128'(p_pmem_address), 0);
    chk("t6_rr_read",    128'(r_pmem_read), 0);
    reset_n = 1; i_read = 0; pmem_rdata = PA5; pmem_resp = 1;
    #1;
    chk("t6_late_i_resp", 128'(p_i_resp), 0);
    chk("t6_late_d_resp", 128'(p_d_resp), 0);
    chk("t6_late_i_rdata", p_i_rdata, 0);
    chk("t6_late_rr_resp", 128'(r_i_resp | r_d_resp), 0);
    tick();
    pmem_resp = 0;
    tick();
    chk("t6_idle_read", 128'(p_pmem_read), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
